// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// next-PC select encodings and the NOP word loaded on flush/reset.
package fetch_stage_pkg;

    localparam int ADDR_W_DEF      = 12;
    localparam int INSTR_W_DEF     = 19;
    localparam int STACK_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        PC_INC    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_RET    = 2'b11
    } pc_sel_e;

    localparam logic [INSTR_W_DEF-1:0] NOP_WORD = '0;

endpackage

// File: rtl/return_stack.sv
// Hardware return-address stack with sticky overflow/underflow/conflict flags.
// Latency: top is combinational from sp; push/pop land on the edge. Backpressure: en=0 freezes all ops.
module return_stack
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = STACK_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_dat,
    output logic [ADDR_W-1:0] top_dat,
    output logic              overflow,
    output logic              underflow,
    output logic              conflict
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp;
    logic [IDX_W-1:0]  top_idx;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign do_push = en & push & ~pop & ~full;
    assign do_pop  = en & pop & ~push & ~empty;
    assign top_idx = IDX_W'(sp - SP_W'(1));

    // An empty stack returns address 0 rather than stale storage.
    assign top_dat = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[sp[IDX_W-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            if (do_push) begin
                sp <= sp + SP_W'(1);
            end else if (do_pop) begin
                sp <= sp - SP_W'(1);
            end
            if (en & push & pop) begin
                conflict <= 1'b1;
            end
            if (en & push & ~pop & full) begin
                overflow <= 1'b1;
            end
            if (en & pop & ~push & empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC register, next-PC select, return stack and IF/ID register.
// Latency: fetched word reaches IF/ID one cycle after its PC. Backpressure: pc_writebar/IF_ID_loadbar hold state.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_writebar,
    input  logic               IF_ID_loadbar,
    input  logic               IF_ID_flush,
    input  logic [1:0]         pc_mux,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               push,
    input  logic               pop,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] IF_ID_instruction,
    output logic [ADDR_W-1:0]  IF_ID_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic               stack_overflow,
    output logic               stack_underflow,
    output logic               stack_conflict
);

    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] ret_dat;
    logic [ADDR_W-1:0] ret_push_dat;

    assign imem_addr    = pc;
    assign instruction  = imem_data;
    assign ret_push_dat = IF_ID_pc + ADDR_W'(1);

    // Stack ops are gated by the IF/ID stall so a stalled call/return acts once.
    return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .en        (~IF_ID_loadbar),
        .push      (push),
        .pop       (pop),
        .push_dat  (ret_push_dat),
        .top_dat   (ret_dat),
        .overflow  (stack_overflow),
        .underflow (stack_underflow),
        .conflict  (stack_conflict)
    );

    always_comb begin
        next_pc = pc + ADDR_W'(1);
        case (pc_sel_e'(pc_mux))
            PC_INC:    next_pc = pc + ADDR_W'(1);
            PC_BRANCH: next_pc = branch_target;
            PC_JUMP:   next_pc = jump_target;
            PC_RET:    next_pc = ret_dat;
            default:   next_pc = pc + ADDR_W'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else if (!pc_writebar) begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || IF_ID_flush) begin
            IF_ID_instruction <= INSTR_W'(NOP_WORD);
            IF_ID_pc          <= '0;
        end else if (!IF_ID_loadbar) begin
            IF_ID_instruction <= instruction;
            IF_ID_pc          <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: stimulus queues expected post-edge
// state, an independent monitor compares it on the following falling edge.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        pc_writebar;
    logic        IF_ID_loadbar;
    logic        IF_ID_flush;
    logic [1:0]  pc_mux;
    logic [11:0] branch_target;
    logic [11:0] jump_target;
    logic        push;
    logic        pop;
    logic [18:0] imem_data;
    logic [11:0] imem_addr;
    logic [18:0] instruction;
    logic [18:0] IF_ID_instruction;
    logic [11:0] IF_ID_pc;
    logic [11:0] pc;
    logic        stack_overflow;
    logic        stack_underflow;
    logic        stack_conflict;

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .pc_writebar       (pc_writebar),
        .IF_ID_loadbar     (IF_ID_loadbar),
        .IF_ID_flush       (IF_ID_flush),
        .pc_mux            (pc_mux),
        .branch_target     (branch_target),
        .jump_target       (jump_target),
        .push              (push),
        .pop               (pop),
        .imem_data         (imem_data),
        .imem_addr         (imem_addr),
        .instruction       (instruction),
        .IF_ID_instruction (IF_ID_instruction),
        .IF_ID_pc          (IF_ID_pc),
        .pc                (pc),
        .stack_overflow    (stack_overflow),
        .stack_underflow   (stack_underflow),
        .stack_conflict    (stack_conflict)
    );

    // Instruction memory: each word equals its own address.
    always_comb imem_data = {7'b0, imem_addr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        string       tag;
        int          due;
        logic [11:0] pc;
        logic [18:0] ii;
        logic [11:0] ipc;
        logic [3:0]  sp;
        logic [2:0]  fl;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   stim_done = 0;

    task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0h required=%0h (cycle %0d)", tag, field, act, exp, cycle);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic cyc(input string tag, input logic rst, input logic wb, input logic lb, input logic fl,
                       input logic [1:0] mux, input logic [11:0] bt, input logic [11:0] jt,
                       input logic pu, input logic po,
                       input logic [11:0] e_pc, input logic [18:0] e_ii, input logic [11:0] e_ipc,
                       input logic [3:0] e_sp, input logic [2:0] e_fl);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        pc_writebar   = wb;
        IF_ID_loadbar = lb;
        IF_ID_flush   = fl;
        pc_mux        = mux;
        branch_target = bt;
        jump_target   = jt;
        push          = pu;
        pop           = po;
        e.tag = tag;
        e.due = cycle + 1;
        e.pc  = e_pc;
        e.ii  = e_ii;
        e.ipc = e_ipc;
        e.sp  = e_sp;
        e.fl  = e_fl;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cycle) begin
                e = q.pop_front();
                chk(e.tag, "pc", pc, e.pc);
                chk(e.tag, "imem_addr", imem_addr, e.pc);
                chk(e.tag, "instruction", instruction, {7'b0, e.pc});
                chk(e.tag, "IF_ID_instruction", IF_ID_instruction, e.ii);
                chk(e.tag, "IF_ID_pc", IF_ID_pc, e.ipc);
                chk(e.tag, "sp", dut.u_stack.sp, e.sp);
                chk(e.tag, "flags", {stack_conflict, stack_underflow, stack_overflow}, e.fl);
            end
        end
    end

    initial begin : stimulus
        logic [11:0] ipc_e;
        reset = 1'b1; pc_writebar = 0; IF_ID_loadbar = 0; IF_ID_flush = 0;
        pc_mux = 2'b00; branch_target = '0; jump_target = '0; push = 0; pop = 0;

        // Reset state
        cyc("rst0", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'h000, 19'h0, 12'h000, 0, 3'b000);
        cyc("rst1", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'h000, 19'h0, 12'h000, 0, 3'b000);

        // Sequential fetch, IF/ID lags by one
        for (int i = 1; i <= 5; i++)
            cyc("seq", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'(i), 19'(i - 1), 12'(i - 1), 0, 3'b000);

        // Stall both PC and IF/ID
        repeat (2) cyc("stall", 0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 12'h005, 19'h4, 12'h004, 0, 3'b000);
        cyc("release", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'h006, 19'h5, 12'h005, 0, 3'b000);

        // Taken branch with flush
        cyc("branch", 0, 0, 0, 1, 2'b01, 12'h040, 0, 0, 0, 12'h040, 19'h0, 12'h000, 0, 3'b000);
        cyc("br_next", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'h041, 19'h040, 12'h040, 0, 3'b000);

        // Call from IF_ID_pc=0x010, then return to 0x011
        cyc("jmp", 0, 0, 0, 0, 2'b10, 0, 12'h010, 0, 0, 12'h010, 19'h041, 12'h041, 0, 3'b000);
        cyc("to_call", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'h011, 19'h010, 12'h010, 0, 3'b000);
        cyc("call", 0, 0, 0, 0, 2'b10, 0, 12'h100, 1, 0, 12'h100, 19'h011, 12'h011, 1, 3'b000);
        cyc("in_sub", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'h101, 19'h100, 12'h100, 1, 3'b000);
        cyc("ret", 0, 0, 0, 0, 2'b11, 0, 0, 0, 1, 12'h011, 19'h101, 12'h101, 0, 3'b000);

        // Stalled call pushes exactly once
        repeat (2) cyc("call_stall", 0, 1, 1, 0, 2'b00, 0, 0, 1, 0, 12'h011, 19'h101, 12'h101, 0, 3'b000);
        cyc("call_go", 0, 0, 0, 0, 2'b10, 0, 12'h200, 1, 0, 12'h200, 19'h011, 12'h011, 1, 3'b000);
        cyc("ret2", 0, 0, 0, 0, 2'b11, 0, 0, 0, 1, 12'h102, 19'h200, 12'h200, 0, 3'b000);

        // Nine pushes: saturate at 8, overflow on the ninth
        for (int k = 1; k <= 9; k++)
            cyc("push_fill", 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 12'(12'h102 + k), 19'(12'h101 + k),
                12'(12'h101 + k), 4'((k > 8) ? 8 : k), (k == 9) ? 3'b001 : 3'b000);

        // Drain: dropped ninth write must not have corrupted any entry
        for (int i = 1; i <= 8; i++) begin
            ipc_e = (i == 1) ? 12'h10B : 12'(12'h10B - i);
            cyc("pop_drain", 0, 0, 0, 0, 2'b11, 0, 0, 0, 1, (i == 8) ? 12'h201 : 12'(12'h10A - i),
                19'(ipc_e), ipc_e, 4'(8 - i), 3'b001);
        end
        cyc("pop_empty", 0, 0, 0, 0, 2'b11, 0, 0, 0, 1, 12'h000, 19'h201, 12'h201, 0, 3'b011);

        // Build sp=3, then push and pop together
        for (int j = 1; j <= 3; j++)
            cyc("push3", 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 12'(j), 19'(j - 1), 12'(j - 1), 4'(j), 3'b011);
        cyc("conflict", 0, 0, 0, 0, 2'b11, 0, 0, 1, 1, 12'h002, 19'h3, 12'h003, 3, 3'b111);
        cyc("rst_flags", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'h000, 19'h0, 12'h000, 0, 3'b000);
        cyc("after_rst", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'h001, 19'h0, 12'h000, 0, 3'b000);

        // PC wrap and flush-over-hold priority
        cyc("jmp_top", 0, 0, 0, 0, 2'b10, 0, 12'hFFF, 0, 0, 12'hFFF, 19'h1, 12'h001, 0, 3'b000);
        cyc("wrap", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'h000, 19'hFFF, 12'hFFF, 0, 3'b000);
        cyc("flush_hold", 0, 1, 1, 1, 2'b00, 0, 0, 0, 0, 12'h000, 19'h0, 12'h000, 0, 3'b000);

        // Reset wins over stall, flush and a pending push
        cyc("pre", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'h001, 19'h0, 12'h000, 0, 3'b000);
        cyc("call_pend", 0, 0, 0, 0, 2'b10, 0, 12'h300, 1, 0, 12'h300, 19'h1, 12'h001, 1, 3'b000);
        cyc("rst_stall", 1, 1, 1, 1, 2'b00, 0, 0, 1, 0, 12'h000, 19'h0, 12'h000, 0, 3'b000);
        cyc("idle", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12'h001, 19'h0, 12'h000, 0, 3'b000);

        for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
